// File: rtl/jtag_master.sv
// jtag_master: JTAG initiator that shifts up to C_data_len bits through IR or DR, idling in Run-Test/Idle
//   clk, rstn          system clock, asynchronous active-low reset
//   start, sel_ir      launch a shift (IR when sel_ir=1), sampled with len/din
//   len, din           bit count (clamped to C_data_len) and TDI data, bit 0 first
//   tap_reset          launch the Test-Logic-Reset -> Run-Test/Idle walk
//   dout               captured TDO bits, dout[i] = i-th bit shifted out
//   busy, done         sequence running, one-clk end-of-shift pulse
//   tck, tms, tdi, tdo JTAG pins toward the target TAP
module jtag_master #(
   parameter int C_data_len = 64,
   parameter int C_clk_div  = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  sel_ir,
   input  logic [6:0]            len,
   input  logic [C_data_len-1:0] din,
   input  logic                  tap_reset,
   output logic [C_data_len-1:0] dout,
   output logic                  busy,
   output logic                  done,
   output logic                  tck,
   output logic                  tms,
   output logic                  tdi,
   input  logic                  tdo
);
   localparam int PW = (2 * C_clk_div > 2) ? $clog2(2 * C_clk_div) : 1;
   localparam logic [PW-1:0] PH_RISE = PW'(C_clk_div - 1);
   localparam logic [PW-1:0] PH_LAST = PW'(2 * C_clk_div - 1);
   typedef enum logic [2:0] {RST_SEQ, IDLE, PRE, SHIFT, POST, FIN} state_t;
   state_t                state;
   logic [PW-1:0]         ph;
   logic [6:0]            cnt, n, len_c;
   logic                  is_ir, last, tdo_m, tdo_s;
   logic [C_data_len-1:0] dreg, mask;
   always_comb begin
      last  = ph == PH_LAST;
      len_c = (len > 7'(C_data_len)) ? 7'(C_data_len) : len;
   end
   // tms/tdi for the next TCK are loaded on the clk that ends a high phase,
   // so they change exactly at the start of each low phase
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= RST_SEQ;
         ph    <= '0;
         cnt   <= '0;
         n     <= '0;
         is_ir <= 1'b0;
         dreg  <= '0;
         mask  <= '0;
         dout  <= '0;
         busy  <= 1'b1;
         done  <= 1'b0;
         tck   <= 1'b0;
         tms   <= 1'b1;
         tdi   <= 1'b0;
         tdo_m <= 1'b0;
         tdo_s <= 1'b0;
      end else begin
         tdo_m <= tdo;
         tdo_s <= tdo_m;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (tap_reset) begin
                  state <= RST_SEQ;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  ph    <= '0;
                  tms   <= 1'b1;
                  tdi   <= 1'b0;
               end else if (start && len_c == 7'd0) begin
                  state <= FIN;
                  done  <= 1'b1;
               end else if (start) begin
                  state <= PRE;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  ph    <= '0;
                  n     <= len_c;
                  is_ir <= sel_ir;
                  dreg  <= din;
                  mask  <= C_data_len'(1);
                  dout  <= '0;
                  tms   <= 1'b1;
                  tdi   <= 1'b0;
               end
            end
            FIN: state <= IDLE;
            default: begin
               ph  <= last ? '0 : ph + 1'b1;
               tck <= !last && ph >= PH_RISE;
               if (last) begin
                  case (state)
                     RST_SEQ: begin
                        if (cnt == 7'd5) begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end else begin
                           cnt <= cnt + 7'd1;
                           tms <= cnt < 7'd4;
                        end
                     end
                     PRE: begin
                        if (cnt == (is_ir ? 7'd3 : 7'd2)) begin
                           state <= SHIFT;
                           cnt   <= '0;
                           tms   <= n == 7'd1;
                           tdi   <= dreg[0];
                           dreg  <= dreg >> 1;
                        end else begin
                           cnt <= cnt + 7'd1;
                           tms <= is_ir && cnt == 7'd0;
                        end
                     end
                     SHIFT: begin
                        // mask walks one-hot over the bit positions being captured
                        dout <= tdo_s ? (dout | mask) : dout;
                        mask <= mask << 1;
                        if (cnt == n - 7'd1) begin
                           state <= POST;
                           cnt   <= '0;
                           tms   <= 1'b1;
                           tdi   <= 1'b0;
                        end else begin
                           cnt  <= cnt + 7'd1;
                           tms  <= cnt + 7'd2 == n;
                           tdi  <= dreg[0];
                           dreg <= dreg >> 1;
                        end
                     end
                     POST: begin
                        if (cnt == 7'd0) begin
                           cnt <= 7'd1;
                           tms <= 1'b0;
                        end else begin
                           state <= FIN;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end
endmodule

// File: doc/jtag_master.md
# jtag_master

Initiator end of the JTAG link: generates TCK/TMS/TDI toward an external TAP (e.g. an ECP5 JTAGG user register on another board) and captures TDO. One command shifts up to C_data_len bits through the IR or DR path, starting and ending in Run-Test/Idle. A separate command drives the TAP into Test-Logic-Reset and back to Run-Test/Idle. It sits beside the hex/OLED debug display, which can show `din`/`dout`.

## Interface
- C_data_len, 64: maximum shift length in bits, 1..64.
- C_clk_div, 4: clk cycles per TCK half-period, ≥1.

- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-clk pulse that launches a shift when `busy`=0.
- sel_ir  in  1  sampled with `start`: 1 = IR path, 0 = DR path.
- len  in  7  sampled with `start`: number of bits to shift.
- din  in  C_data_len  sampled with `start`: TDI data, bit 0 shifted first.
- tap_reset  in  1  one-clk pulse that launches the TLR→RTI sequence when `busy`=0.
- dout  out  C_data_len  captured TDO bits; `dout[i]` = i-th bit shifted out.
- busy  out  1  high while a sequence runs.
- done  out  1  one-clk pulse at the end of a `start` transaction.
- tck  out  1  JTAG clock; idles low.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target; asynchronous input.

## Operation
- `tdo` passes through a 2-FF synchronizer before use.
- TCK period = 2·C_clk_div clks: low phase first, then high phase.
  - `tms`/`tdi` update on the first clk of each low phase.
  - `tdo_sync` is sampled on the last clk of each high phase.
- State machine: RST_SEQ, IDLE, PRE (state-walk to Shift), SHIFT, POST (Exit1→Update→RTI), FIN.
- RST_SEQ: 6 TCKs with TMS = 1,1,1,1,1,0; TDI = 0.
- DR transaction TMS, one value per TCK:
  - PRE: 1,0,0.
  - SHIFT: len bits, TMS = 0 except the last bit, which has TMS = 1.
  - POST: 1,0.
  - Total len+5 TCKs.
- IR transaction: PRE is 1,1,0,0. Total len+6 TCKs.
- TDI during SHIFT is `din[k]` for bit k = 0..len-1. TDI is 0 outside SHIFT.
- `dout` is cleared at `start`; bit k is stored on the high-phase sample of SHIFT bit k. Bits ≥ len read 0.
- `len` greater than C_data_len is clamped to C_data_len.
- `len` = 0: no TCK is generated, `done` pulses on the next clk, and `dout` is left unchanged.
- `start` or `tap_reset` while `busy`=1 is ignored (not queued).
- `start` and `tap_reset` in the same clk: `tap_reset` wins and `start` is dropped.
- `tap_reset` sequences raise `busy` but never pulse `done`.

## Timing
- Reset values, held while `rstn`=0:
  - busy=1, done=0, dout=0, tck=0, tms=1, tdi=0.
  - State = RST_SEQ, so an automatic TLR sequence runs after `rstn` is released.
- `rstn` asserted mid-transaction aborts it immediately, asynchronously. There is no `done`; the TAP is re-synchronized by the automatic RST_SEQ.
- Start latency: the first TCK low phase begins on the clk after the `start` pulse (`busy` rises that same clk).
- End of sequence: after the last high phase, `tck` returns low. On that clk `busy` falls and `done` pulses (for `start` transactions only).
- Clks from `start` to `done`:
  - DR: (len+5)·2·C_clk_div + 1.
  - IR: (len+6)·2·C_clk_div + 1.
- A new `start` is accepted on the clk after `done`.

## Test plan
- Power-up: release `rstn` → 6 TCKs with TMS 1,1,1,1,1,0 → `busy` falls, `done` never pulses, and the TAP model is in RTI.
- DR, len=8, din=0xA5; TAP model returns 0x3C:
  - TMS = 1,0,0, 0×7, 1, 1,0.
  - TDI in SHIFT = 1,0,1,0,0,1,0,1.
  - dout=0x3C, one `done` pulse, 13·2·C_clk_div+1 clks.
- IR, len=4, din=0x9 → TMS = 1,1,0,0, 0,0,0,1, 1,0 (10 TCKs); the TAP model IR equals 0x9 at Update-IR.
- DR, len=64, target in BYPASS (captures 0, 1-bit delay), din=0xFFFF_FFFF_FFFF_FFFF → dout=0xFFFF_FFFF_FFFF_FFFE. With len=70, the TCK count is 69 (clamped to 64 bits).
- Command conflicts:
  - `start` while `busy` → no effect.
  - `start` and `tap_reset` in the same clk → only the 6-TCK reset sequence, no `done`.
  - `len`=0 → `done` on the next clk, `tck` stays 0.
- Reset mid-SHIFT: assert `rstn` at bit 3 → tck=0, tms=1, busy=1, dout=0 immediately; after release, the automatic TLR sequence runs and `done` never pulses.
